// File: rtl/ff_piso_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ff_piso_pkg
//  Purpose  : Shared types and helpers for the PISO serializer.
//  Revision : 1.0 - initial release
// ============================================================================
package ff_piso_pkg;

    // Serializer FSM: waiting for a word, or driving frame bits onto sout.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit-index counter width. Never narrower than one bit.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : ff_piso_pkg
`default_nettype wire

// File: rtl/ff_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : ff_piso_serializer
//  Purpose  : Parallel-in / serial-out shifter with valid/ready load,
//             clock enable and first/last frame strobes. in_ready rises on
//             the last bit of a frame so back-to-back words are gapless.
//  Revision : 1.0 - initial release
// ============================================================================
module ff_piso_serializer
    import ff_piso_pkg::*;
#(
    parameter int   WIDTH      = 5,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_first,
    output logic             sout_last,
    output logic             busy
);

    localparam int              CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_PENULT = CNT_W'(WIDTH - 2);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-2:0]   r_shreg;
    logic               r_sout;
    logic               r_sout_valid;
    logic               r_sout_first;
    logic               r_sout_last;

    logic               w_at_last;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_load_bit;
    logic [WIDTH-2:0]   w_load_rest;
    logic               w_shift_bit;
    logic [WIDTH-2:0]   w_shift_rest;

    // Handshake: ready in IDLE or while the final frame bit is on the line.
    // Held low during reset so nothing is accepted while the block is cleared.
    assign w_at_last  = (r_cnt == c_LAST);
    assign w_in_ready = cen & ~rst &
                        ((r_state == IDLE) | ((r_state == SHIFT) & w_at_last));
    assign w_accept   = in_valid & w_in_ready;

    // Bit-order selection: which bit leaves first and which end the
    // remainder drains from.
    always_comb begin
        if (MSB_FIRST) begin
            w_load_bit   = in_data[WIDTH-1];
            w_load_rest  = in_data[WIDTH-2:0];
            w_shift_bit  = r_shreg[WIDTH-2];
            w_shift_rest = r_shreg << 1;
        end else begin
            w_load_bit   = in_data[0];
            w_load_rest  = in_data[WIDTH-1:1];
            w_shift_bit  = r_shreg[0];
            w_shift_rest = r_shreg >> 1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: an accept always (re)starts a frame; otherwise leave SHIFT
    // after the last bit. Everything holds while cen is low.
    always_comb begin
        w_state_nxt = r_state;
        if (cen) begin
            if (w_accept) begin
                w_state_nxt = SHIFT;
            end else if ((r_state == SHIFT) && w_at_last) begin
                w_state_nxt = IDLE;
            end
        end
    end

    // Datapath: load on accept, shift one bit per enabled cycle, return the
    // line to its idle level when a frame ends without a follow-on word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_shreg      <= '0;
            r_sout       <= IDLE_LEVEL;
            r_sout_valid <= 1'b0;
            r_sout_first <= 1'b0;
            r_sout_last  <= 1'b0;
        end else if (cen) begin
            if (w_accept) begin
                r_sout       <= w_load_bit;
                r_shreg      <= w_load_rest;
                r_cnt        <= '0;
                r_sout_valid <= 1'b1;
                r_sout_first <= 1'b1;
                r_sout_last  <= 1'b0;
            end else if (r_state == SHIFT) begin
                if (!w_at_last) begin
                    r_sout       <= w_shift_bit;
                    r_shreg      <= w_shift_rest;
                    r_cnt        <= r_cnt + CNT_W'(1);
                    r_sout_first <= 1'b0;
                    r_sout_last  <= (r_cnt == c_PENULT);
                end else begin
                    r_sout       <= IDLE_LEVEL;
                    r_sout_valid <= 1'b0;
                    r_sout_first <= 1'b0;
                    r_sout_last  <= 1'b0;
                end
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign sout       = r_sout;
    assign sout_valid = r_sout_valid;
    assign sout_first = r_sout_first;
    assign sout_last  = r_sout_last;
    assign busy       = (r_state == SHIFT);

endmodule : ff_piso_serializer
`default_nettype wire

// File: tb/tb_ff_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ff_piso_serializer
//  Purpose  : Directed-vector bench. Two instances share one stimulus:
//             A = MSB first, idle level 0; B = LSB first, idle level 1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ff_piso_serializer;

    logic       clk;
    logic       rst;
    logic       cen;
    logic [4:0] in_data;
    logic       in_valid;

    logic a_ready, a_sout, a_valid, a_first, a_last, a_busy;
    logic b_ready, b_sout, b_valid, b_first, b_last, b_busy;

    int n_total;
    int n_pass;

    ff_piso_serializer #(.WIDTH(5), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut_a (
        .clk(clk), .rst(rst), .cen(cen), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_ready), .sout(a_sout), .sout_valid(a_valid),
        .sout_first(a_first), .sout_last(a_last), .busy(a_busy)
    );

    ff_piso_serializer #(.WIDTH(5), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .cen(cen), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_ready), .sout(b_sout), .sout_valid(b_valid),
        .sout_first(b_first), .sout_last(b_last), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rdy is checked just before the edge; the rest just after it.
    typedef struct {
        logic       cen;
        logic       vld;
        logic [4:0] data;
        logic       rdy;
        logic       a;
        logic       b;
        logic       ov;
        logic       of;
        logic       ol;
        logic       bsy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic c, input logic v, input logic [4:0] d,
                                input logic r, input logic a, input logic b,
                                input logic ov, input logic of, input logic ol,
                                input logic bs);
        vec_t t;
        t.cen = c; t.vld = v; t.data = d; t.rdy = r; t.a = a; t.b = b;
        t.ov = ov; t.of = of; t.ol = ol; t.bsy = bs;
        return t;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        cen      = v.cen;
        in_valid = v.vld;
        in_data  = v.data;
        #1;
        chk({tag, " a_in_ready"}, a_ready, v.rdy);
        chk({tag, " b_in_ready"}, b_ready, v.rdy);
        @(posedge clk);
        #1;
        chk({tag, " a_sout"},  a_sout,  v.a);
        chk({tag, " b_sout"},  b_sout,  v.b);
        chk({tag, " a_valid"}, a_valid, v.ov);
        chk({tag, " b_valid"}, b_valid, v.ov);
        chk({tag, " a_first"}, a_first, v.of);
        chk({tag, " b_first"}, b_first, v.of);
        chk({tag, " a_last"},  a_last,  v.ol);
        chk({tag, " b_last"},  b_last,  v.ol);
        chk({tag, " a_busy"},  a_busy,  v.bsy);
        chk({tag, " b_busy"},  b_busy,  v.bsy);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " a_sout"},  a_sout,  1'b0);
        chk({tag, " b_sout"},  b_sout,  1'b1);
        chk({tag, " a_valid"}, a_valid, 1'b0);
        chk({tag, " b_valid"}, b_valid, 1'b0);
        chk({tag, " a_first"}, a_first, 1'b0);
        chk({tag, " a_last"},  a_last,  1'b0);
        chk({tag, " a_busy"},  a_busy,  1'b0);
        chk({tag, " b_busy"},  b_busy,  1'b0);
        chk({tag, " a_in_ready"}, a_ready, 1'b0);
        chk({tag, " b_in_ready"}, b_ready, 1'b0);
    endtask

    initial begin
        n_total  = 0;
        n_pass   = 0;
        rst      = 1'b1;
        cen      = 1'b1;
        in_valid = 1'b0;
        in_data  = 5'b0;

        //            cen vld data     rdy a  b  ov of ol bsy
        // Frame 10110: A 1,0,1,1,0  B 0,1,1,0,1
        vecs.push_back(mk(1, 1, 5'b10110, 1, 1, 0, 1, 1, 0, 1));
        vecs.push_back(mk(1, 0, 5'b00000, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 5'b00000, 0, 1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 5'b00000, 0, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 5'b00000, 0, 0, 1, 1, 0, 1, 1));
        vecs.push_back(mk(1, 0, 5'b00000, 1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 5'b00000, 1, 0, 1, 0, 0, 0, 0));
        // 11001 then valid held with changing data; 00001 taken at cnt==4
        vecs.push_back(mk(1, 1, 5'b11001, 1, 1, 1, 1, 1, 0, 1));
        vecs.push_back(mk(1, 1, 5'b00111, 0, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 1, 5'b01111, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 1, 5'b00001, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 1, 5'b00001, 0, 1, 1, 1, 0, 1, 1));
        vecs.push_back(mk(1, 1, 5'b00001, 1, 0, 1, 1, 1, 0, 1));
        vecs.push_back(mk(1, 0, 5'b00000, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 5'b00000, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 5'b00000, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 5'b00000, 0, 1, 0, 1, 0, 1, 1));
        vecs.push_back(mk(1, 0, 5'b00000, 1, 0, 1, 0, 0, 0, 0));
        // cen toggling with 11001: A 1,1,0,0,1  B 1,0,0,1,1
        vecs.push_back(mk(1, 1, 5'b11001, 1, 1, 1, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 5'b00000, 0, 1, 1, 1, 1, 0, 1));
        vecs.push_back(mk(1, 0, 5'b00000, 0, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 5'b00000, 0, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 5'b00000, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 5'b00000, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 5'b00000, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 5'b00000, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 5'b00000, 0, 1, 1, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 5'b00000, 0, 1, 1, 1, 0, 1, 1));
        vecs.push_back(mk(1, 0, 5'b00000, 1, 0, 1, 0, 0, 0, 0));
        // cen low in idle blocks the handshake
        vecs.push_back(mk(0, 1, 5'b11111, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 5'b00000, 1, 0, 1, 0, 0, 0, 0));

        // Reset values while rst is asserted (cen high, so in_ready must be gated)
        #2;
        chk_reset_state("por");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Async reset in the third cycle of a frame
        apply(mk(1, 1, 5'b10110, 1, 1, 0, 1, 1, 0, 1), "rs0");
        apply(mk(1, 0, 5'b00000, 0, 0, 1, 1, 0, 0, 1), "rs1");
        apply(mk(1, 0, 5'b00000, 0, 1, 1, 1, 0, 0, 1), "rs2");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_state("midrst");
        @(negedge clk);
        rst = 1'b0;

        // Fresh frame 01010: A 0,1,0,1,0  B 0,1,0,1,0
        apply(mk(1, 1, 5'b01010, 1, 0, 0, 1, 1, 0, 1), "post0");
        apply(mk(1, 0, 5'b00000, 0, 1, 1, 1, 0, 0, 1), "post1");
        apply(mk(1, 0, 5'b00000, 0, 0, 0, 1, 0, 0, 1), "post2");
        apply(mk(1, 0, 5'b00000, 0, 1, 1, 1, 0, 0, 1), "post3");
        apply(mk(1, 0, 5'b00000, 0, 0, 0, 1, 0, 1, 1), "post4");
        apply(mk(1, 0, 5'b00000, 1, 0, 1, 0, 0, 0, 0), "post5");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_ff_piso_serializer
`default_nettype wire
